// File: rtl/mem_access_unit.sv
// mem_access_unit: splits word/half/byte loads and stores into big-endian single-byte accesses on a byte-wide RAM
module mem_access_unit #(
  parameter int RAM_ADDR_BITS = 10
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req,
  input  logic                     wena,
  input  logic                     w,
  input  logic                     h,
  input  logic                     b,
  input  logic                     z,
  input  logic [31:0]              addr,
  input  logic [31:0]              wdata,
  output logic                     busy,
  output logic                     done,
  output logic [31:0]              rdata,
  output logic                     addr_err,
  output logic                     ram_ena,
  output logic                     ram_wena,
  output logic [RAM_ADDR_BITS-1:0] ram_addr,
  output logic [7:0]               ram_din,
  input  logic [7:0]               ram_dout
);
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  state_t state, state_nxt;
  logic [1:0] cnt, last, sh;
  logic [RAM_ADDR_BITS-1:0] la;
  logic [31:0] lwd, acc, acc_nxt, ld_ext;
  logic lwena, lw, lh, lz, err, req_err, access;
  always_comb begin
    req_err = ~((w ^ h ^ b) & ~(w & h & b)) | (h & addr[0]) | (w & |addr[1:0]) | (|(addr >> RAM_ADDR_BITS));
    last = lw ? 2'd3 : lh ? 2'd1 : 2'd0;
    sh = last - cnt;
    access = state == ACCESS;
    acc_nxt = {acc[23:0], ram_dout};
    ld_ext = lw ? acc_nxt : lh ? {{16{~lz & acc_nxt[15]}}, acc_nxt[15:0]} : {{24{~lz & acc_nxt[7]}}, acc_nxt[7:0]};
    state_nxt = state == IDLE ? (req ? (req_err ? DONE : ACCESS) : IDLE) :
                state == ACCESS ? (cnt == last ? DONE : ACCESS) : IDLE;
    busy = state != IDLE;
    done = state == DONE;
    addr_err = done & err;
    // RAM side decodes only from registered state, gated to zero outside ACCESS
    ram_ena = access;
    ram_wena = access & lwena;
    ram_addr = access ? la + RAM_ADDR_BITS'(cnt) : '0;
    ram_din = (access & lwena) ? lwd[{sh, 3'b000} +: 8] : 8'h00;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      cnt <= 2'd0;
      acc <= '0;
      rdata <= '0;
      la <= '0;
      lwd <= '0;
      lwena <= 1'b0;
      lw <= 1'b0;
      lh <= 1'b0;
      lz <= 1'b0;
      err <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && req) begin
        la <= addr[RAM_ADDR_BITS-1:0];
        lwd <= wdata;
        lwena <= wena;
        lw <= w;
        lh <= h;
        lz <= z;
        err <= req_err;
        cnt <= 2'd0;
      end
      if (access) begin
        cnt <= cnt == last ? 2'd0 : cnt + 2'd1;
        if (!lwena) acc <= acc_nxt;
        if (!lwena && cnt == last) rdata <= ld_ext;
      end
    end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed scoreboard bench for mem_access_unit with a behavioural byte RAM
module tb_mem_access_unit;
  logic clk = 1'b0, rst_n = 1'b0, req = 1'b0, wena = 1'b0, w = 1'b0, h = 1'b0, b = 1'b0, z = 1'b0;
  logic [31:0] addr = '0, wdata = '0;
  logic busy, done, addr_err, ram_ena, ram_wena;
  logic [31:0] rdata;
  logic [9:0] ram_addr;
  logic [7:0] ram_din, ram_dout;
  logic [7:0] mem [0:1023];
  typedef struct {string tag; logic [31:0] rd; logic err; int lat; int ena;} exp_t;
  exp_t sb[$];
  int n_cmp = 0, n_bad = 0;

  mem_access_unit #(.RAM_ADDR_BITS(10)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .wena(wena), .w(w), .h(h), .b(b), .z(z),
    .addr(addr), .wdata(wdata), .busy(busy), .done(done), .rdata(rdata), .addr_err(addr_err),
    .ram_ena(ram_ena), .ram_wena(ram_wena), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout)
  );

  always #5 clk = ~clk;
  assign ram_dout = mem[ram_addr];
  always @(posedge clk) if (ram_ena && ram_wena) mem[ram_addr] <= ram_din;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " rdata"}, rdata, 32'h0);
    check({tag, " flags"}, {29'd0, busy, done, addr_err}, 32'h0);
    check({tag, " ram"}, {12'd0, ram_ena, ram_wena, ram_addr, ram_din}, 32'h0);
  endtask

  task automatic access(input string tag, input bit we, input bit ww, input bit hh, input bit bb, input bit zz,
                        input logic [31:0] a, input logic [31:0] d, input bit eerr, input logic [31:0] erd);
    int cyc, enas;
    exp_t e;
    sb.push_back('{tag, erd, eerr, eerr ? 1 : ww ? 5 : hh ? 3 : 2, eerr ? 0 : ww ? 4 : hh ? 2 : 1});
    wena = we; w = ww; h = hh; b = bb; z = zz; addr = a; wdata = d; req = 1'b1;
    @(posedge clk); #1;
    req = 1'b0;
    cyc = 1; enas = 0;
    while (!done && cyc < 20) begin
      enas += int'(ram_ena);
      @(posedge clk); #1;
      cyc++;
    end
    e = sb.pop_front();
    check({e.tag, " done"}, {31'd0, done}, 32'd1);
    check({e.tag, " latency"}, cyc, e.lat);
    check({e.tag, " enables"}, enas, e.ena);
    check({e.tag, " addr_err"}, {31'd0, addr_err}, {31'd0, e.err});
    check({e.tag, " rdata"}, rdata, e.rd);
    @(posedge clk); #1;
    check({e.tag, " idle after done"}, {30'd0, busy, done}, 32'd0);
  endtask

  initial begin
    int cyc, enas;
    #1;
    check_reset_outputs("reset");
    #21 rst_n = 1'b1;
    @(posedge clk); #1;
    check("idle busy", {31'd0, busy}, 32'd0);

    access("st_w10", 1, 1, 0, 0, 0, 32'h10, 32'h11223344, 0, 32'h0);
    check("mem 10..13", {mem[16], mem[17], mem[18], mem[19]}, 32'h11223344);
    access("ld_w10", 0, 1, 0, 0, 0, 32'h10, 32'h0, 0, 32'h11223344);
    access("st_h20", 1, 0, 1, 0, 0, 32'h20, 32'h00008001, 0, 32'h11223344);
    access("ld_b20s", 0, 0, 0, 1, 0, 32'h20, 32'h0, 0, 32'hFFFFFF80);
    access("ld_b20z", 0, 0, 0, 1, 1, 32'h20, 32'h0, 0, 32'h00000080);
    access("ld_h20s", 0, 0, 1, 0, 0, 32'h20, 32'h0, 0, 32'hFFFF8001);
    access("ld_h20z", 0, 0, 1, 0, 1, 32'h20, 32'h0, 0, 32'h00008001);
    access("ld_b21", 0, 0, 0, 1, 0, 32'h21, 32'h0, 0, 32'h00000001);

    access("err_h3", 0, 0, 1, 0, 0, 32'h3, 32'h0, 1, 32'h00000001);
    access("err_w6", 0, 1, 0, 0, 0, 32'h6, 32'h0, 1, 32'h00000001);
    access("err_wh", 0, 1, 1, 0, 0, 32'h0, 32'h0, 1, 32'h00000001);
    access("err_none", 0, 0, 0, 0, 0, 32'h0, 32'h0, 1, 32'h00000001);
    access("err_w400", 0, 1, 0, 0, 0, 32'h400, 32'h0, 1, 32'h00000001);
    access("err_st_hi", 1, 1, 0, 0, 0, 32'h8000_0010, 32'hDEADBEEF, 1, 32'h00000001);
    check("mem untouched by err", {mem[16], mem[17], mem[18], mem[19]}, 32'h11223344);

    access("st_b30", 1, 0, 0, 1, 0, 32'h30, 32'hFFFFFF33, 0, 32'h00000001);
    access("ld_b30", 0, 0, 0, 1, 0, 32'h30, 32'h0, 0, 32'h00000033);
    access("st_h42", 1, 0, 1, 0, 0, 32'h42, 32'h00005A5A, 0, 32'h00000033);

    wena = 1; w = 1; h = 0; b = 0; z = 0; addr = 32'h40; wdata = 32'hAABBCCDD; req = 1'b1;
    @(posedge clk); #1;
    req = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    check("mid-store ram_ena", {31'd0, ram_ena}, 32'd1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid-store reset");
    check("mem 40..43", {mem[64], mem[65], mem[66], mem[67]}, 32'hAABB5A5A);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    access("ld_w40", 0, 1, 0, 0, 0, 32'h40, 32'h0, 0, 32'hAABB5A5A);

    wena = 1; w = 1; h = 0; b = 0; z = 0; addr = 32'h50; wdata = 32'h01020304; req = 1'b1;
    @(posedge clk); #1;
    cyc = 1; enas = 0;
    while (!done && cyc < 20) begin
      enas += int'(ram_ena);
      wdata = $urandom;
      @(posedge clk); #1;
      cyc++;
    end
    req = 1'b0;
    check("hold done", {31'd0, done}, 32'd1);
    check("hold latency", cyc, 32'd5);
    check("hold enables", enas, 32'd4);
    repeat (3) begin
      @(posedge clk); #1;
      check("hold no requeue", {30'd0, busy, done}, 32'd0);
    end
    check("mem 50..53", {mem[80], mem[81], mem[82], mem[83]}, 32'h01020304);
    access("ld_w50", 0, 1, 0, 0, 0, 32'h50, 32'h0, 0, 32'h01020304);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
